// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU engine feeding the HI/LO write mux; MULTDIV_FAST_MUL_EN selects a single-cycle multiply path
module multdiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nx;
  logic [1:0]  op_q;
  logic [31:0] md, a_raw;
  logic [63:0] acc;
  logic [4:0]  cnt;
  logic        neg_q, neg_r;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum, div_r;
  logic [31:0] div_d;
  logic        div_ge;
  logic [63:0] mul_nx, div_nx, prod_mag, prod;
  logic [31:0] quo, rem, res_hi, res_lo;
  // operand magnitudes for the signed ops
  always_comb begin
    abs_a = (!op[0] && a[31]) ? -a : a;
    abs_b = (!op[0] && b[31]) ? -b : b;
  end
  // one radix-2 iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, md} : 33'd0);
    mul_nx  = {mul_sum, acc[31:1]};
    div_r   = acc[63:31];
    div_ge  = div_r >= {1'b0, md};
    div_d   = div_r[31:0] - md;
    div_nx  = div_ge ? {div_d, acc[30:0], 1'b1} : {div_r[31:0], acc[30:0], 1'b0};
  end
  // sign correction and result selection, divide-by-zero overrides
  always_comb begin
`ifdef MULTDIV_FAST_MUL_EN
    prod_mag = 64'(md) * 64'(acc[31:0]);
`else
    prod_mag = acc;
`endif
    prod   = neg_q ? -prod_mag : prod_mag;
    quo    = neg_q ? -acc[31:0] : acc[31:0];
    rem    = neg_r ? -acc[63:32] : acc[63:32];
    res_hi = !op_q[1] ? prod[63:32] : (md == 32'd0) ? a_raw : rem;
    res_lo = !op_q[1] ? prod[31:0] : (md == 32'd0) ? 32'hFFFFFFFF : quo;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next-state: 32 RUN iterations between accept and fix-up
  always_comb begin
    state_nx = state;
    case (state)
`ifdef MULTDIV_FAST_MUL_EN
      IDLE: state_nx = start ? (op[1] ? RUN : FIX) : IDLE;
`else
      IDLE: state_nx = start ? RUN : IDLE;
`endif
      RUN:  state_nx = (cnt == 5'd31) ? FIX : RUN;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // datapath: latch operands on accept, iterate in RUN, publish in FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      op_q  <= '0;
      md    <= '0;
      a_raw <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_q  <= op;
          md    <= op[1] ? abs_b : abs_a;
          acc   <= {32'd0, op[1] ? abs_a : abs_b};
          a_raw <= a;
          neg_q <= !op[0] && (a[31] ^ b[31]);
          neg_r <= !op[0] && a[31];
          cnt   <= '0;
          busy  <= 1'b1;
        end
        RUN: begin
          acc <= op_q[1] ? div_nx : mul_nx;
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
